// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared types for the main-memory arbiter (FSM states, owner IDs,
//          byte-lane type and word<->lane packing helpers).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;

  // Lane i carries word bits [8i+7:8i].
  typedef logic [0:WORD_BYTES-1][7:0] lanes_t;

  function automatic lanes_t word_to_lanes(input logic [31:0] w);
    lanes_t l;
    for (int i = 0; i < WORD_BYTES; i++) l[i] = w[8*i +: 8];
    return l;
  endfunction

  function automatic logic [31:0] lanes_to_word(input lanes_t l);
    logic [31:0] w;
    for (int i = 0; i < WORD_BYTES; i++) w[8*i +: 8] = l[i];
    return w;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Purpose: bundle of icache/dcache request-response signals and the memory port.
// Latency: n/a (wires only).
// Backpressure: req held by the cache until its one-cycle ready pulse.
// Ports: ic_req/ic_addr -> ic_ready/ic_rdata; dc_req/dc_we/dc_addr/dc_wdata ->
//        dc_ready/dc_rdata; mem_addr/mem_write_en/mem_data_in/mem_busy out to memory,
//        mem_data_out back from memory.
//        slave  = the arbiter's view; master = caches + memory model.
interface mem_arbiter_if #(parameter int ADDR_W = 32);
  import mem_arb_pkg::*;

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ready;
  logic [31:0]       ic_rdata;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [31:0]       dc_wdata;
  logic              dc_ready;
  logic [31:0]       dc_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write_en;
  lanes_t            mem_data_in;
  lanes_t            mem_data_out;
  logic              mem_busy;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_data_out,
    output ic_ready, ic_rdata, dc_ready, dc_rdata,
           mem_addr, mem_write_en, mem_data_in, mem_busy
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_data_out,
    input  ic_ready, ic_rdata, dc_ready, dc_rdata,
           mem_addr, mem_write_en, mem_data_in, mem_busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one main-memory word port between icache (read) and dcache (r/w).
// Latency: grant edge -> MEM_LATENCY BUSY cycles -> one RESP cycle with ready pulse.
// Backpressure: one transfer in flight; other requester waits (req held) until IDLE.
// Ports: clk, rst_b (async, active-low), bus (mem_arbiter_if.slave).
// Params: MEM_LATENCY (1..15) cycles memory needs inputs stable; ADDR_W address width.
// Options: MEM_ARB_RR_EN defined -> round-robin on ties; undefined -> dcache priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 32
) (
  input  logic          clk,
  input  logic          rst_b,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  state_t            r_state;
  owner_t            r_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_busy;
  logic              r_ic_rdy;
  logic              r_dc_rdy;
  logic [31:0]       r_ic_rdata;
  logic [31:0]       r_dc_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  lanes_t            r_lanes;
  owner_t            w_grant;

`ifdef MEM_ARB_RR_EN
  // Owner of the most recent grant; starts at icache so dcache wins the first tie.
  owner_t r_last;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_last <= OWN_IC;
    end else if (r_state == IDLE && (bus.ic_req || bus.dc_req)) begin
      r_last <= w_grant;
    end
  end
`endif

  always_comb begin
    w_grant = OWN_DC;
    if (bus.ic_req && !bus.dc_req) begin
      w_grant = OWN_IC;
    end
`ifdef MEM_ARB_RR_EN
    else if (bus.ic_req && bus.dc_req && r_last == OWN_DC) begin
      w_grant = OWN_IC;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= IDLE;
      r_owner    <= OWN_IC;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_ic_rdy   <= 1'b0;
      r_dc_rdy   <= 1'b0;
      r_ic_rdata <= '0;
      r_dc_rdata <= '0;
      r_mem_addr <= '0;
      r_lanes    <= '0;
    end else begin
      r_ic_rdy <= 1'b0;
      r_dc_rdy <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.ic_req || bus.dc_req) begin
            r_state <= BUSY;
            r_owner <= w_grant;
            r_cnt   <= CNT_W'(MEM_LATENCY - 1);
            r_busy  <= 1'b1;
            if (w_grant == OWN_DC) begin
              r_mem_addr <= {bus.dc_addr[ADDR_W-1:2], 2'b00};
              r_we       <= bus.dc_we;
              r_lanes    <= word_to_lanes(bus.dc_wdata);
            end else begin
              // icache reads leave the write lanes at their last value.
              r_mem_addr <= {bus.ic_addr[ADDR_W-1:2], 2'b00};
              r_we       <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            if (!r_we) begin
              if (r_owner == OWN_IC) r_ic_rdata <= lanes_to_word(bus.mem_data_out);
              else                   r_dc_rdata <= lanes_to_word(bus.mem_data_out);
            end
            r_we     <= 1'b0;
            r_state  <= RESP;
            r_ic_rdy <= (r_owner == OWN_IC);
            r_dc_rdy <= (r_owner == OWN_DC);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          // No arbitration here: a held req is picked up in the next IDLE cycle.
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ic_ready     = r_ic_rdy;
  assign bus.ic_rdata     = r_ic_rdata;
  assign bus.dc_ready     = r_dc_rdy;
  assign bus.dc_rdata     = r_dc_rdata;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_write_en = r_we;
  assign bus.mem_data_in  = r_lanes;
  assign bus.mem_busy     = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter (MEM_LATENCY 4 and 1 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_b;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus4 ();
  mem_arbiter_if #(.ADDR_W(32)) bus1 ();

  mem_arbiter #(.MEM_LATENCY(4), .ADDR_W(32)) u_dut4 (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus4.slave)
  );

  mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) u_dut1 (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem4(input logic [7:0] l0, l1, l2, l3);
    bus4.mem_data_out[0] = l0;
    bus4.mem_data_out[1] = l1;
    bus4.mem_data_out[2] = l2;
    bus4.mem_data_out[3] = l3;
  endtask

  initial begin
    bus4.ic_req = 1'b0; bus4.ic_addr = '0; bus4.dc_req = 1'b0; bus4.dc_we = 1'b0;
    bus4.dc_addr = '0;  bus4.dc_wdata = '0; bus4.mem_data_out = '0;
    bus1.ic_req = 1'b0; bus1.ic_addr = '0; bus1.dc_req = 1'b0; bus1.dc_we = 1'b0;
    bus1.dc_addr = '0;  bus1.dc_wdata = '0; bus1.mem_data_out = '0;
    rst_b = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst ic_ready", 32'(bus4.ic_ready), 32'd0);
    chk("rst dc_ready", 32'(bus4.dc_ready), 32'd0);
    chk("rst mem_write_en", 32'(bus4.mem_write_en), 32'd0);
    chk("rst mem_busy", 32'(bus4.mem_busy), 32'd0);
    chk("rst ic_rdata", bus4.ic_rdata, 32'd0);
    chk("rst dc_rdata", bus4.dc_rdata, 32'd0);
    chk("rst mem_addr", bus4.mem_addr, 32'd0);
    chk("rst mem_data_in", 32'(bus4.mem_data_in), 32'd0);
    chk("rst l1 ic_ready", 32'(bus1.ic_ready), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    step();

    // IC read: lanes 11,22,33,44 -> 0x44332211, ready in cycle 5
    set_mem4(8'h11, 8'h22, 8'h33, 8'h44);
    bus4.ic_addr = 32'h206;
    bus4.ic_req  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("icrd ic_ready c%0d", c), 32'(bus4.ic_ready), 32'(c == 5));
      chk($sformatf("icrd mem_busy c%0d", c), 32'(bus4.mem_busy), 32'(c <= 5));
      chk($sformatf("icrd mem_write_en c%0d", c), 32'(bus4.mem_write_en), 32'd0);
      chk($sformatf("icrd dc_ready c%0d", c), 32'(bus4.dc_ready), 32'd0);
      if (c == 1) chk("icrd mem_addr", bus4.mem_addr, 32'h204);
      if (c == 5) bus4.ic_req = 1'b0;
    end
    chk("icrd ic_rdata", bus4.ic_rdata, 32'h44332211);

    // Simultaneous requests
    set_mem4(8'h88, 8'h77, 8'h66, 8'h55);
    bus4.dc_we   = 1'b0;
    bus4.dc_addr = 32'h40;
    bus4.ic_addr = 32'h80;
    bus4.ic_req  = 1'b1;
    bus4.dc_req  = 1'b1;
`ifdef MEM_ARB_RR_EN
    for (int c = 1; c <= 24; c++) begin
      step();
      chk($sformatf("rr dc_ready c%0d", c), 32'(bus4.dc_ready), 32'(c == 5 || c == 17));
      chk($sformatf("rr ic_ready c%0d", c), 32'(bus4.ic_ready), 32'(c == 11 || c == 23));
      if (c == 23) begin
        bus4.ic_req = 1'b0;
        bus4.dc_req = 1'b0;
      end
    end
`else
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("prio dc_ready c%0d", c), 32'(bus4.dc_ready), 32'(c == 5));
      chk($sformatf("prio ic_ready c%0d", c), 32'(bus4.ic_ready), 32'(c == 11));
      if (c == 5)  bus4.dc_req = 1'b0;
      if (c == 11) bus4.ic_req = 1'b0;
    end
`endif
    chk("tie ic_rdata", bus4.ic_rdata, 32'h55667788);
    chk("tie dc_rdata", bus4.dc_rdata, 32'h55667788);

    // DC read at unaligned 0x103; req dropped early and address changed after grant
    set_mem4(8'h0D, 8'hF0, 8'hFE, 8'hCA);
    bus4.dc_we   = 1'b0;
    bus4.dc_addr = 32'h103;
    bus4.dc_req  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("dcrd dc_ready c%0d", c), 32'(bus4.dc_ready), 32'(c == 5));
      chk($sformatf("dcrd mem_write_en c%0d", c), 32'(bus4.mem_write_en), 32'd0);
      if (c == 1) chk("dcrd mem_addr", bus4.mem_addr, 32'h100);
      if (c == 2) begin
        bus4.dc_req  = 1'b0;
        bus4.dc_addr = 32'h999;
      end
      if (c == 3) chk("dcrd mem_addr held", bus4.mem_addr, 32'h100);
    end
    chk("dcrd dc_rdata", bus4.dc_rdata, 32'hCAFEF00D);

    // DC write 0xDEADBEEF to 0x100; dc_rdata must not change
    set_mem4(8'h78, 8'h56, 8'h34, 8'h12);
    bus4.dc_we    = 1'b1;
    bus4.dc_addr  = 32'h100;
    bus4.dc_wdata = 32'hDEADBEEF;
    bus4.dc_req   = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("dcwr mem_write_en c%0d", c), 32'(bus4.mem_write_en), 32'(c <= 4));
      chk($sformatf("dcwr dc_ready c%0d", c), 32'(bus4.dc_ready), 32'(c == 5));
      if (c == 1) begin
        chk("dcwr mem_addr", bus4.mem_addr, 32'h100);
        chk("dcwr lane0", 32'(bus4.mem_data_in[0]), 32'hEF);
        chk("dcwr lane1", 32'(bus4.mem_data_in[1]), 32'hBE);
        chk("dcwr lane2", 32'(bus4.mem_data_in[2]), 32'hAD);
        chk("dcwr lane3", 32'(bus4.mem_data_in[3]), 32'hDE);
      end
      if (c == 5) bus4.dc_req = 1'b0;
    end
    chk("dcwr dc_rdata kept", bus4.dc_rdata, 32'hCAFEF00D);

    // Reset during cycle 2 of a write
    bus4.dc_addr  = 32'h200;
    bus4.dc_wdata = 32'h01020304;
    bus4.dc_req   = 1'b1;
    step();
    step();
    chk("rstw mem_write_en before", 32'(bus4.mem_write_en), 32'd1);
    chk("rstw mem_busy before", 32'(bus4.mem_busy), 32'd1);
    #2;
    rst_b = 1'b0;
    bus4.dc_req = 1'b0;
    bus4.dc_we  = 1'b0;
    #1;
    chk("rstw mem_write_en async", 32'(bus4.mem_write_en), 32'd0);
    chk("rstw mem_busy async", 32'(bus4.mem_busy), 32'd0);
    chk("rstw mem_addr async", bus4.mem_addr, 32'd0);
    chk("rstw dc_rdata async", bus4.dc_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("rstw no dc_ready c%0d", c), 32'(bus4.dc_ready), 32'd0);
      chk($sformatf("rstw idle c%0d", c), 32'(bus4.mem_busy), 32'd0);
    end
    set_mem4(8'hD4, 8'hC3, 8'hB2, 8'hA1);
    bus4.ic_addr = 32'h10;
    bus4.ic_req  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("post ic_ready c%0d", c), 32'(bus4.ic_ready), 32'(c == 5));
      if (c == 5) bus4.ic_req = 1'b0;
    end
    chk("post ic_rdata", bus4.ic_rdata, 32'hA1B2C3D4);

    // MEM_LATENCY=1 back-to-back reads with ic_req held: ready every 3 cycles
    bus1.mem_data_out[0] = 8'h0D;
    bus1.mem_data_out[1] = 8'hF0;
    bus1.mem_data_out[2] = 8'hAD;
    bus1.mem_data_out[3] = 8'h0B;
    bus1.ic_addr = 32'h44;
    bus1.ic_req  = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      chk($sformatf("l1 ic_ready c%0d", c), 32'(bus1.ic_ready), 32'(c == 2 || c == 5 || c == 8));
      chk($sformatf("l1 mem_busy c%0d", c), 32'(bus1.mem_busy), 32'(c % 3 != 0));
      if (c == 8) bus1.ic_req = 1'b0;
    end
    chk("l1 ic_rdata", bus1.ic_rdata, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction cache (read-only) and the data cache (read/write). Each transfer is one 32-bit word on the four-byte-lane memory bus. The block sequences each transfer: it holds address, write data and write enable stable for the fixed memory latency, then captures read data and returns a one-cycle ready pulse to the winning requester. It sits between the fetch/MEM-stage caches and the memory model.

## Interface
Parameters:
- MEM_LATENCY, 4: cycles the memory needs address/data held stable; legal range 1..15.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- ic_req  in  1  instruction-cache request; held high until ic_ready.
- ic_addr  in  ADDR_W  instruction-cache word address.
- ic_ready  out  1  one-cycle pulse: ic_rdata valid.
- ic_rdata  out  32  read word for the instruction cache.
- dc_req  in  1  data-cache request; held high until dc_ready.
- dc_we  in  1  1 = write, 0 = read.
- dc_addr  in  ADDR_W  data-cache word address.
- dc_wdata  in  32  write word.
- dc_ready  out  1  one-cycle pulse: read data valid or write committed.
- dc_rdata  out  32  read word for the data cache.
- mem_addr  out  ADDR_W  memory address, with bits [1:0] forced to 0.
- mem_write_en  out  1  memory write enable.
- mem_data_in  out  8 x [0:3]  write lanes; lane i = word[8i+7:8i].
- mem_data_out  in  8 x [0:3]  read lanes; same lane mapping.
- mem_busy  out  1  high while not IDLE.

## Operation
- FSM states:
  - IDLE: arbitrates.
  - BUSY: transfer in flight; down-counter cnt is active.
  - RESP: ready pulse cycle.
- IDLE -> BUSY at the clock edge on which any req is sampled high. At that edge:
  - latch the owner, address, write flag and write data;
  - load cnt with MEM_LATENCY-1.
- BUSY:
  - mem_addr, mem_data_in and mem_write_en (= latched write flag) are driven from the latched values.
  - cnt decrements each cycle.
  - When cnt==0, at that edge: capture mem_data_out into the owner's rdata register (reads only), then go to RESP.
- RESP: assert the owner's ready; go to IDLE unconditionally.
- Arbitration when both requests are high in IDLE: dcache wins (strict priority); see Configuration for the round-robin alternative.
- rdata registers hold their value until the next read for that requester. A write does not alter dc_rdata.
- Outside BUSY:
  - mem_write_en = 0;
  - mem_addr and mem_data_in hold their last value.
- Protocol violation (req dropped before ready): the transfer still completes and ready still pulses. Payload changes after grant are ignored.

## Timing
- Reset values: ic_ready = dc_ready = mem_write_en = mem_busy = 0; ic_rdata = dc_rdata = mem_addr = 0; mem_data_in lanes = 0; state IDLE; cnt = 0.
- Request first sampled high at edge of cycle 0:
  - BUSY covers cycles 1..MEM_LATENCY;
  - ready is high in cycle MEM_LATENCY+1;
  - IDLE in cycle MEM_LATENCY+2.
- Throughput: one transfer per MEM_LATENCY+2 cycles.
- A requester may keep req high through its ready cycle to issue a new transfer. That req is arbitrated in the following IDLE cycle.
- MEM_LATENCY = 1: BUSY lasts exactly one cycle; data is sampled at the end of that cycle.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous). The transfer is dropped with no ready pulse, and mem_write_en deasserts without waiting for a clock.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A last-grant register records the owner of each granted transfer; reset value = icache.
  - On a tie, the requester that did not win last is granted, so after reset dcache wins the first tie.
  - Single requests are granted regardless of last-grant.
- MEM_ARB_RR_EN undefined: fixed dcache priority; no last-grant register.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, BUSY, RESP);
  - owner enum (OWN_IC, OWN_DC);
  - localparam WORD_BYTES = 4.
- cnt width = $clog2(MEM_LATENCY+1).
- No sub-module. Counter, lane packing and arbitration are inline.

## Test plan
- IC read, MEM_LATENCY = 4, memory returns lanes {0x11, 0x22, 0x33, 0x44} for lanes 0..3 -> ic_ready in cycle 5; ic_rdata = 0x44332211; mem_write_en stays 0.
- DC write to 0x100 with 0xDEADBEEF -> mem_write_en high for exactly cycles 1..4; mem_addr = 0x100; lanes {0xEF, 0xBE, 0xAD, 0xDE}; dc_ready in cycle 5; dc_rdata unchanged.
- ic_req and dc_req rise together:
  - without the macro: dc served first, ic ready in cycle 11;
  - with MEM_ARB_RR_EN, both held for 4 transfers: grant order dc, ic, dc, ic.
- dc_addr = 0x103 -> mem_addr = 0x100.
- Assert rst_b = 0 in cycle 2 of a write -> mem_write_en and mem_busy drop asynchronously, no dc_ready pulse; after release, a new IC read completes normally.
- MEM_LATENCY = 1, back-to-back IC reads with ic_req held high -> ready pulses every 3 cycles.
